// File: rtl/reduce_gate_pipe_if.sv
// Operand/result handshake bundle for the pipelined reduction gate.
// master drives operands and out_ready; slave is the gate itself.
interface reduce_gate_pipe_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [2:0]       in_mode;
   logic             out_valid;
   logic             out_ready;
   logic             out_bit;
   logic [2:0]       out_mode;
   logic             out_err;
   logic             busy;

   modport master (
      output in_valid, in_data, in_mode, out_ready,
      input  in_ready, out_valid, out_bit, out_mode, out_err, busy
   );

   modport slave (
      input  in_valid, in_data, in_mode, out_ready,
      output in_ready, out_valid, out_bit, out_mode, out_err, busy
   );
endinterface

// File: rtl/reduce_gate_pipe.sv
// Pipelined WIDTH-input reduction gate (AND/OR/XOR and inversions) built as a
// registered binary tree with valid/ready flow control on both sides.
module reduce_gate_pipe #(
   parameter int WIDTH  = 8,
   parameter int LEVELS = $clog2(WIDTH)
) (
   input  logic clk,
   input  logic rst_n,
   reduce_gate_pipe_if.slave s_bus
);
   localparam int P  = 1 << LEVELS;
   localparam int NB = 2 * P - 1;

   typedef enum logic [1:0] {FN_AND, FN_OR, FN_XOR} fn_e;

   function automatic fn_e base_fn(input logic [2:0] mode);
      case (mode)
         3'd0, 3'd3: return FN_AND;
         3'd2, 3'd5: return FN_XOR;
         default:    return FN_OR;
      endcase
   endfunction

   function automatic logic red2(input fn_e fn, input logic a, input logic b);
      case (fn)
         FN_AND:  return a & b;
         FN_XOR:  return a ^ b;
         default: return a | b;
      endcase
   endfunction

   function automatic logic [P-1:0] low_ones();
      logic [P-1:0] m;
      m = '0;
      m[WIDTH-1:0] = '1;
      return m;
   endfunction

   localparam logic [P-1:0] PAD_MASK = ~low_ones();

   // All stages packed into one vector: stage k starts at bit 2P - 2*(P>>k).
   logic [LEVELS:0]         r_valid;
   logic [NB-1:0]           r_data;
   logic [3*(LEVELS+1)-1:0] r_mode;

   logic [LEVELS:0]         w_rdy;
   logic [LEVELS:0]         w_valid_nxt;
   logic [NB-1:0]           w_data_nxt;
   logic [3*(LEVELS+1)-1:0] w_mode_nxt;
   logic [P-1:0]            w_op;
   logic                    w_load0;

   // A stage can take new data if any stage from it to the output has a hole.
   for (genvar k = 0; k <= LEVELS; k++) begin : g_rdy
      assign w_rdy[k] = s_bus.out_ready || !(&r_valid[LEVELS:k]);
   end

   always_comb begin
      w_op = '0;
      w_op[WIDTH-1:0] = s_bus.in_data;
      if (base_fn(s_bus.in_mode) == FN_AND) w_op = w_op | PAD_MASK;
   end

   assign w_load0              = s_bus.in_valid && w_rdy[0];
   assign w_valid_nxt[0]       = w_rdy[0] ? s_bus.in_valid : r_valid[0];
   assign w_data_nxt[P-1:0]    = w_load0 ? w_op : r_data[P-1:0];
   assign w_mode_nxt[2:0]      = w_load0 ? s_bus.in_mode : r_mode[2:0];

   for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
      localparam int NI = P >> (k - 1);
      localparam int NO = P >> k;
      localparam int OI = 2 * P - 2 * NI;
      localparam int OO = 2 * P - 2 * NO;

      logic [NI-1:0] w_in;
      logic [NO-1:0] w_red;
      logic [2:0]    w_mode_up;
      fn_e           w_fn_up;
      logic          w_load;

      assign w_in      = r_data[OI +: NI];
      assign w_mode_up = r_mode[3*(k-1) +: 3];
      assign w_fn_up   = base_fn(w_mode_up);
      assign w_load    = r_valid[k-1] && w_rdy[k];

      for (genvar j = 0; j < NO; j++) begin : g_pair
         assign w_red[j] = red2(w_fn_up, w_in[2*j], w_in[2*j+1]);
      end

      assign w_valid_nxt[k]       = w_rdy[k] ? r_valid[k-1] : r_valid[k];
      assign w_data_nxt[OO +: NO] = w_load ? w_red : r_data[OO +: NO];
      assign w_mode_nxt[3*k +: 3] = w_load ? w_mode_up : r_mode[3*k +: 3];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         r_data  <= '0;
         r_mode  <= '0;
      end else begin
         r_valid <= w_valid_nxt;
         r_data  <= w_data_nxt;
         r_mode  <= w_mode_nxt;
      end
   end

   logic [2:0] w_mode_out;
   logic       w_err;
   logic       w_inv;

   assign w_mode_out = r_mode[3*LEVELS +: 3];
   assign w_err      = (w_mode_out == 3'd6) || (w_mode_out == 3'd7);
   assign w_inv      = (w_mode_out == 3'd3) || (w_mode_out == 3'd4) || (w_mode_out == 3'd5);

   // Result is forced to 0 when idle or reserved so it never carries stale data.
   assign s_bus.out_valid = r_valid[LEVELS];
   assign s_bus.out_bit   = r_valid[LEVELS] && !w_err && (r_data[NB-1] ^ w_inv);
   assign s_bus.out_mode  = w_mode_out;
   assign s_bus.out_err   = r_valid[LEVELS] && w_err;
   assign s_bus.busy      = |r_valid;
   assign s_bus.in_ready  = rst_n && w_rdy[0];
endmodule

// File: tb/tb_reduce_gate_pipe.sv
// Directed bench for reduce_gate_pipe at WIDTH=3, 5 and 8 with hand-computed results.
module tb_reduce_gate_pipe;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   reduce_gate_pipe_if #(.WIDTH(3)) if3();
   reduce_gate_pipe_if #(.WIDTH(5)) if5();
   reduce_gate_pipe_if #(.WIDTH(8)) if8();

   reduce_gate_pipe #(.WIDTH(3)) u3 (.clk(clk), .rst_n(rst_n), .s_bus(if3));
   reduce_gate_pipe #(.WIDTH(5)) u5 (.clk(clk), .rst_n(rst_n), .s_bus(if5));
   reduce_gate_pipe #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .s_bus(if8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] t2_d [6] = '{8'hFF, 8'hFE, 8'h00, 8'h80, 8'h07, 8'h07};
   logic [2:0] t2_m [6] = '{3'd0, 3'd0, 3'd1, 3'd4, 3'd2, 3'd5};
   logic       t2_e [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

   logic [7:0] t3_d [6] = '{8'hFF, 8'h00, 8'h03, 8'h00, 8'h0F, 8'h01};
   logic [2:0] t3_m [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
   logic       t3_e [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

   logic [4:0] t4_d [4] = '{5'b11111, 5'b00001, 5'b00000, 5'b11111};
   logic [2:0] t4_m [4] = '{3'd3, 3'd2, 3'd4, 3'd0};
   logic       t4_e [4] = '{1'b0, 1'b1, 1'b1, 1'b1};

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      if3.in_valid = 1'b0; if3.in_data = '0; if3.in_mode = 3'd0; if3.out_ready = 1'b1;
      if5.in_valid = 1'b0; if5.in_data = '0; if5.in_mode = 3'd0; if5.out_ready = 1'b1;
      if8.in_valid = 1'b0; if8.in_data = '0; if8.in_mode = 3'd0; if8.out_ready = 1'b1;
      #2;

      chk("rst_out_valid", 8'(if8.out_valid), 8'd0);
      chk("rst_busy",      8'(if8.busy),      8'd0);
      chk("rst_out_bit",   8'(if8.out_bit),   8'd0);
      chk("rst_in_ready",  8'(if8.in_ready),  8'd0);
      chk("rst_in_ready3", 8'(if3.in_ready),  8'd0);

      tick(); tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_in_ready", 8'(if8.in_ready), 8'd1);

      // WIDTH=3 AND over all eight patterns
      for (int i = 0; i < 10; i++) begin
         if3.in_valid = (i < 8);
         if3.in_data  = 3'(i);
         if3.in_mode  = 3'd0;
         tick();
         if (i < 2) begin
            chk("w3_latency_valid", 8'(if3.out_valid), 8'd0);
         end else begin
            chk("w3_valid", 8'(if3.out_valid), 8'd1);
            chk("w3_bit",   8'(if3.out_bit),   (i == 9) ? 8'd1 : 8'd0);
         end
      end
      tick();
      chk("w3_drained", 8'(if3.out_valid), 8'd0);

      // WIDTH=8 back-to-back mixed modes
      for (int i = 0; i < 9; i++) begin
         if8.in_valid = (i < 6);
         if (i < 6) begin
            if8.in_data = t2_d[i];
            if8.in_mode = t2_m[i];
         end
         tick();
         if (i == 2) chk("w8_latency_valid", 8'(if8.out_valid), 8'd0);
         if (i >= 3) begin
            chk("w8_valid", 8'(if8.out_valid), 8'd1);
            chk("w8_bit",   8'(if8.out_bit),   8'(t2_e[i-3]));
            chk("w8_mode",  8'(if8.out_mode),  8'(t2_m[i-3]));
         end
      end
      tick();
      chk("w8_drained", 8'(if8.out_valid), 8'd0);

      // WIDTH=8 backpressure: fill four stages, stall, then drain
      if8.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("bp_in_ready_fill", 8'(if8.in_ready), 8'd1);
         if8.in_valid = 1'b1;
         if8.in_data  = t3_d[i];
         if8.in_mode  = t3_m[i];
         tick();
      end
      chk("bp_in_ready_full", 8'(if8.in_ready),  8'd0);
      chk("bp_busy",          8'(if8.busy),      8'd1);
      chk("bp_out_valid",     8'(if8.out_valid), 8'd1);
      if8.in_data = t3_d[4];
      if8.in_mode = t3_m[4];
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("bp_hold_in_ready", 8'(if8.in_ready), 8'd0);
         chk("bp_hold_bit",      8'(if8.out_bit),  8'(t3_e[0]));
         chk("bp_hold_mode",     8'(if8.out_mode), 8'(t3_m[0]));
      end
      if8.out_ready = 1'b1;
      #1;
      chk("bp_ready_chain", 8'(if8.in_ready), 8'd1);
      for (int j = 1; j < 6; j++) begin
         if (j == 2) begin
            if8.in_data = t3_d[5];
            if8.in_mode = t3_m[5];
         end
         if (j == 3) if8.in_valid = 1'b0;
         tick();
         chk("bp_drain_valid", 8'(if8.out_valid), 8'd1);
         chk("bp_drain_bit",   8'(if8.out_bit),   8'(t3_e[j]));
         chk("bp_drain_mode",  8'(if8.out_mode),  8'(t3_m[j]));
      end
      tick();
      chk("bp_empty_valid", 8'(if8.out_valid), 8'd0);
      chk("bp_empty_busy",  8'(if8.busy),      8'd0);

      // WIDTH=5 padding identities
      for (int i = 0; i < 7; i++) begin
         if5.in_valid = (i < 4);
         if (i < 4) begin
            if5.in_data = t4_d[i];
            if5.in_mode = t4_m[i];
         end
         tick();
         if (i >= 3) begin
            chk("w5_valid", 8'(if5.out_valid), 8'd1);
            chk("w5_bit",   8'(if5.out_bit),   8'(t4_e[i-3]));
         end
      end

      // WIDTH=8 reserved mode then normal mode
      for (int i = 0; i < 5; i++) begin
         if8.in_valid = (i < 2);
         if8.in_data  = 8'hFF;
         if8.in_mode  = (i == 0) ? 3'd6 : 3'd0;
         tick();
         if (i == 2) chk("rsv_latency_valid", 8'(if8.out_valid), 8'd0);
         if (i == 3) begin
            chk("rsv_err",  8'(if8.out_err),  8'd1);
            chk("rsv_bit",  8'(if8.out_bit),  8'd0);
            chk("rsv_mode", 8'(if8.out_mode), 8'd6);
         end
         if (i == 4) begin
            chk("rsv_next_err", 8'(if8.out_err), 8'd0);
            chk("rsv_next_bit", 8'(if8.out_bit), 8'd1);
         end
      end

      // Reset with operands in flight
      for (int i = 0; i < 4; i++) begin
         if8.in_valid = (i < 3);
         if8.in_data  = 8'h0F;
         if8.in_mode  = 3'd1;
         tick();
      end
      chk("inflight_out_valid", 8'(if8.out_valid), 8'd1);
      chk("inflight_busy",      8'(if8.busy),      8'd1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", 8'(if8.out_valid), 8'd0);
      chk("async_rst_busy",      8'(if8.busy),      8'd0);
      chk("async_rst_out_bit",   8'(if8.out_bit),   8'd0);
      chk("async_rst_out_mode",  8'(if8.out_mode),  8'd0);
      chk("async_rst_in_ready",  8'(if8.in_ready),  8'd0);
      tick(); tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("no_stale_valid", 8'(if8.out_valid), 8'd0);
      end
      if8.in_valid = 1'b1;
      if8.in_data  = 8'h00;
      if8.in_mode  = 3'd3;
      tick();
      if8.in_valid = 1'b0;
      tick();
      chk("post_rst_lat1", 8'(if8.out_valid), 8'd0);
      tick();
      chk("post_rst_lat2", 8'(if8.out_valid), 8'd0);
      tick();
      chk("post_rst_valid", 8'(if8.out_valid), 8'd1);
      chk("post_rst_bit",   8'(if8.out_bit),   8'd1);
      chk("post_rst_mode",  8'(if8.out_mode),  8'd3);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
